// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS datapath: walks each instruction through
// IF/ID/EX/MEM/WB and raises the architectural write strobes only in the proper cycle.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             reg_wr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             timeout
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_ALU   = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_BR    = 3'd4,
    CL_JAL   = 3'd5,
    CL_SYS   = 3'd6,
    CL_ILL   = 3'd7
  } cls_t;

  localparam logic [7:0] WAIT_LIM    = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_LIM_M1 = 8'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur_state;
  state_t     nxt_state;
  cls_t       cls_q;
  cls_t       dec_cls;
  logic [7:0] wait_cnt;

  logic ir_c;
  logic pc_c;
  logic rg_c;
  logic mr_c;
  logic mw_c;
  logic timeout_hit;

  always_comb begin
    dec_cls = CL_ILL;
    case (op)
      6'h00: begin
        if (funct == 6'h08)      dec_cls = CL_BR;
        else if (funct == 6'h0C) dec_cls = CL_SYS;
        else                     dec_cls = CL_ALU;
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_cls = CL_ALU;
      6'h23:                      dec_cls = CL_LOAD;
      6'h2B:                      dec_cls = CL_STORE;
      6'h02, 6'h04, 6'h05:        dec_cls = CL_BR;
      6'h03:                      dec_cls = CL_JAL;
      default:                    dec_cls = CL_ILL;
    endcase
  end

  // An illegal opcode retires in ID itself, so ID looks at the live decode
  // rather than the class register, which only captures it on the ID edge.
  always_comb begin
    nxt_state   = cur_state;
    ir_c        = 1'b0;
    pc_c        = 1'b0;
    rg_c        = 1'b0;
    mr_c        = 1'b0;
    mw_c        = 1'b0;
    timeout_hit = 1'b0;
    case (cur_state)
      ST_IF: begin
        ir_c      = 1'b1;
        nxt_state = ST_ID;
      end
      ST_ID: begin
        case (dec_cls)
          CL_SYS:  nxt_state = ST_HALT;
          CL_ILL: begin
            pc_c      = 1'b1;
            nxt_state = ST_IF;
          end
          default: nxt_state = ST_EX;
        endcase
      end
      ST_EX: begin
        case (cls_q)
          CL_LOAD, CL_STORE: nxt_state = ST_MEM;
          CL_ALU, CL_JAL:    nxt_state = ST_WB;
          default: begin
            pc_c      = 1'b1;
            nxt_state = ST_IF;
          end
        endcase
      end
      ST_MEM: begin
        if (wait_cnt == WAIT_LIM) begin
          pc_c      = 1'b1;
          nxt_state = ST_IF;
        end else begin
          mr_c = (cls_q == CL_LOAD);
          mw_c = (cls_q != CL_LOAD);
          if (mem_ready) begin
            if (cls_q == CL_LOAD) begin
              nxt_state = ST_WB;
            end else begin
              pc_c      = 1'b1;
              nxt_state = ST_IF;
            end
          end else begin
            timeout_hit = (wait_cnt == WAIT_LIM_M1);
          end
        end
      end
      ST_WB: begin
        rg_c      = 1'b1;
        pc_c      = 1'b1;
        nxt_state = ST_IF;
      end
      ST_HALT: nxt_state = ST_HALT;
      default: nxt_state = ST_IF;
    endcase
  end

  // Strobes are forced low while reset is held so the datapath sees no write.
  assign state  = cur_state;
  assign ir_wr  = ir_c & ~rst;
  assign pc_wr  = pc_c & ~rst;
  assign reg_wr = rg_c & ~rst;
  assign mem_rd = mr_c & ~rst;
  assign mem_wr = mw_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_IF;
      cls_q     <= CL_NOP;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == ST_ID) cls_q <= dec_cls;
    end
  end

  // The wait counter only survives while the FSM stays in MEM, which can only
  // happen on a not-ready cycle below the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (cur_state == ST_MEM && nxt_state == ST_MEM) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (pc_c) retired <= retired + CNT_ONE;
      if (cur_state == ST_ID && dec_cls == CL_ILL) illegal <= 1'b1;
      if (timeout_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle trace, and a compare process checks every cycle.
module tb_multicycle_ctrl;

  localparam int CNT_W    = 32;
  localparam int MAX_WAIT = 15;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_SYS = 5, K_ILL = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       op = 6'h00;
  logic [5:0]       funct = 6'h00;
  logic             mem_ready = 1'b0;
  logic [2:0]       state;
  logic             ir_wr, pc_wr, reg_wr, mem_rd, mem_wr;
  logic [CNT_W-1:0] retired;
  logic             illegal, timeout;

  typedef struct {
    logic [2:0]  st;
    logic        ir, pc, rg, mr, mw, rdy;
    logic [31:0] ret;
    logic        ill, to;
  } cyc_t;

  cyc_t        exp_q[$];
  cyc_t        trace[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_retired = 0;
  logic        m_illegal = 1'b0;
  logic        m_timeout = 1'b0;

  multicycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .state(state), .ir_wr(ir_wr), .pc_wr(pc_wr), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .retired(retired),
    .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return (f == 6'h08) ? K_BR : (f == 6'h0C) ? K_SYS : K_ALU;
    if (o inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) return K_ALU;
    if (o == 6'h23) return K_LOAD;
    if (o == 6'h2B) return K_STORE;
    if (o inside {6'h02, 6'h04, 6'h05}) return K_BR;
    if (o == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  // Each cycle records the architectural counters as they look during that
  // cycle; a retirement is only visible from the following cycle.
  function automatic void add_cycle(input logic [2:0] st, input logic ir, input logic pc,
                                    input logic rg, input logic mr, input logic mw,
                                    input logic rdy);
    cyc_t c;
    c.st = st; c.ir = ir; c.pc = pc; c.rg = rg; c.mr = mr; c.mw = mw; c.rdy = rdy;
    c.ret = m_retired; c.ill = m_illegal; c.to = m_timeout;
    trace.push_back(c);
    if (pc) m_retired = m_retired + 1;
  endfunction

  function automatic void build_trace(input logic [5:0] o, input logic [5:0] f, input int nwait);
    int   k;
    logic ld;
    trace.delete();
    k  = classify(o, f);
    ld = (k == K_LOAD);
    add_cycle(3'd0, 1, 0, 0, 0, 0, 1);
    if (k == K_ILL) begin
      add_cycle(3'd1, 0, 1, 0, 0, 0, 1);
      m_illegal = 1'b1;
    end else if (k == K_SYS) begin
      add_cycle(3'd1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) add_cycle(3'd5, 0, 0, 0, 0, 0, 1);
    end else begin
      add_cycle(3'd1, 0, 0, 0, 0, 0, 1);
      if (k == K_BR) begin
        add_cycle(3'd2, 0, 1, 0, 0, 0, 1);
      end else if (k == K_ALU || k == K_JAL) begin
        add_cycle(3'd2, 0, 0, 0, 0, 0, 1);
        add_cycle(3'd4, 0, 1, 1, 0, 0, 1);
      end else begin
        add_cycle(3'd2, 0, 0, 0, 0, 0, 1);
        if (nwait >= MAX_WAIT) begin
          for (int i = 0; i < MAX_WAIT; i++) add_cycle(3'd3, 0, 0, 0, ld, !ld, 0);
          m_timeout = 1'b1;
          add_cycle(3'd3, 0, 1, 0, 0, 0, 0);
        end else begin
          for (int i = 0; i < nwait; i++) add_cycle(3'd3, 0, 0, 0, ld, !ld, 0);
          add_cycle(3'd3, 0, !ld, 0, ld, !ld, 1);
          if (ld) add_cycle(3'd4, 0, 1, 1, 0, 0, 1);
        end
      end
    end
  endfunction

  // Entered and left at 1 time unit after the rising edge that opens an IF cycle.
  task automatic run_trace(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
    for (int i = 0; i < trace.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      mem_ready = trace[i].rdy;
      exp_q.push_back(trace[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int nwait);
    build_trace(o, f, nwait);
    run_trace(o, f);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_model();
    m_retired = 0;
    m_illegal = 1'b0;
    m_timeout = 1'b0;
  endtask

  initial begin : compare_proc
    cyc_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (state !== e.st || ir_wr !== e.ir || pc_wr !== e.pc || reg_wr !== e.rg ||
            mem_rd !== e.mr || mem_wr !== e.mw || retired !== e.ret ||
            illegal !== e.ill || timeout !== e.to) begin
          n_errors++;
          $display("[TB] FAIL cycle t=%0t: got st=%0d ir=%b pc=%b rg=%b rd=%b wr=%b ret=%0d ill=%b to=%b, expected st=%0d ir=%b pc=%b rg=%b rd=%b wr=%b ret=%0d ill=%b to=%b",
                   $time, state, ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, retired, illegal, timeout,
                   e.st, e.ir, e.pc, e.rg, e.mr, e.mw, e.ret, e.ill, e.to);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    reset_model();
    #2;
    checkOutput("reset_state", 32'(state), 0);
    checkOutput("reset_ir_wr", 32'(ir_wr), 0);
    checkOutput("reset_pc_wr", 32'(pc_wr), 0);
    checkOutput("reset_retired", retired, 0);
    checkOutput("reset_illegal", 32'(illegal), 0);
    checkOutput("reset_timeout", 32'(timeout), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(6'h00, 6'h20, 0);
    checkOutput("retired_after_add", retired, 1);
    applyStimulus(6'h23, 6'h00, 3);
    checkOutput("retired_after_lw", retired, 2);
    applyStimulus(6'h2B, 6'h00, 0);
    checkOutput("retired_after_sw", retired, 3);
    applyStimulus(6'h04, 6'h00, 0);
    checkOutput("retired_after_beq", retired, 4);
    applyStimulus(6'h2B, 6'h00, 100);
    checkOutput("retired_after_sw_timeout", retired, 5);
    checkOutput("timeout_sticky", 32'(timeout), 1);
    applyStimulus(6'h3F, 6'h00, 0);
    checkOutput("illegal_sticky", 32'(illegal), 1);
    checkOutput("retired_after_illegal", retired, 6);
    applyStimulus(6'h03, 6'h00, 0);
    checkOutput("retired_after_jal", retired, 7);
    checkOutput("timeout_still_set", 32'(timeout), 1);

    build_trace(6'h23, 6'h00, 100);
    while (trace.size() > 5) void'(trace.pop_back());
    run_trace(6'h23, 6'h00);
    checkOutput("lw_state_before_rst", 32'(state), 3);
    checkOutput("lw_mem_rd_before_rst", 32'(mem_rd), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_state", 32'(state), 0);
    checkOutput("midrst_mem_rd", 32'(mem_rd), 0);
    checkOutput("midrst_retired", retired, 0);
    checkOutput("midrst_illegal", 32'(illegal), 0);
    checkOutput("midrst_timeout", 32'(timeout), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();

    applyStimulus(6'h00, 6'h08, 0);
    checkOutput("retired_after_jr", retired, 1);
    applyStimulus(6'h0D, 6'h00, 0);
    checkOutput("retired_after_ori", retired, 2);
    applyStimulus(6'h23, 6'h00, 0);
    checkOutput("retired_after_lw0", retired, 3);
    applyStimulus(6'h00, 6'h0C, 0);
    checkOutput("halt_state", 32'(state), 5);
    checkOutput("halt_retired", retired, 3);
    checkOutput("halt_pc_wr", 32'(pc_wr), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
